collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
//  Parametrised, sequential successor to the combinational car/obstacle collision check.
//  On each frame_tick it snapshots the car and N_OBS obstacle positions.
//  It then tests one obstacle per clock with a full rectangle-overlap test (car size and obstacle size both count).
//  On a collision it emits a 1-cycle reset_game pulse, decrements lives and starts a frame-counted invulnerability window.
//  Sits between the object-position logic and the game-control/VGA layers.
// PARAMETERS
//  N_OBS       4   number of obstacle channels (1..16)
//  H_W         10  horizontal coordinate width
//  V_W         9   vertical coordinate width
//  CAR_W       40  car width, pixels
//  CAR_H       60  car height, pixels
//  OBS_W       50  obstacle width, pixels
//  OBS_H       50  obstacle height, pixels
//  HOLD_FRAMES 60  invulnerability length after a hit, in frame_ticks (>=1)
//  LIVES       3   lives at reset/restart (1..15)
// PORTS
//  clk         in   1            system clock
//  rst_n       in   1            asynchronous active-low reset
//  frame_tick  in   1            1-cycle pulse per video frame; starts a scan
//  restart     in   1            1-cycle pulse; restores lives, clears game_over
//  car_h_pos   in   H_W          car left edge
//  car_v_pos   in   V_W          car top edge
//  obs_h_flat  in   N_OBS*H_W    obstacle i left edge at [i*H_W +: H_W]
//  obs_v_flat  in   N_OBS*V_W    obstacle i top edge at [i*V_W +: V_W]
//  obs_valid   in   N_OBS        per-obstacle enable; 0 = never collides
//  busy        out  1            high while in SCAN
//  reset_game  out  1            1-cycle pulse per registered collision
//  hit_idx     out  clog2(N_OBS) index of last hit (lowest index wins within a scan)
//  lives       out  4            remaining lives
//  invuln      out  1            high during HOLD
//  game_over   out  1            sticky; high when lives reach 0
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - state=IDLE; busy=0, reset_game=0, hit_idx=0, invuln=0, game_over=0, lives=LIVES.
//   - Internal snapshot, index and hold counter cleared.
//  Overlap test, obstacle i:
//   - Collision = car_h < oh+OBS_W && oh < car_h+CAR_W && car_v < ov+OBS_H && ov < car_v+CAR_H && obs_valid[i].
//   - Sums are computed 1 bit wider (H_W+1 / V_W+1); no wrap-around.
//   - Edges that merely touch are not a hit.
//  FSM states: IDLE, SCAN, HIT, HOLD, OVER.
//   - IDLE: on frame_tick at cycle t, snapshot all inputs and go to SCAN.
//   - SCAN (busy=1): idx 0..N_OBS-1 checked at cycles t+1..t+N_OBS; first hit index is latched.
//     - After idx N_OBS-1: go to HIT if any hit, else IDLE.
//     - frame_tick during SCAN is ignored (not queued).
//   - HIT (one cycle, t+N_OBS+1):
//     - reset_game=1; hit_idx updated; lives decremented (saturates at 0).
//     - If the new lives value is 0: game_over=1, go to OVER. Otherwise go to HOLD.
//   - HOLD (invuln=1): counts frame_ticks and returns to IDLE on the HOLD_FRAMES-th tick.
//     - That tick does not start a scan.
//   - OVER: no scans; reset_game stays 0.
//  restart:
//   - Accepted in any state.
//   - Forces lives=LIVES, game_over=0, invuln=0, hold counter=0, state=IDLE next cycle.
//   - Aborts a scan in progress; suppresses a HIT in the same cycle.
//  Simultaneous frame_tick and restart: restart wins; no scan starts.
//  Input changes during SCAN do not affect the result (snapshot only).
//  All outputs are registered.
// TESTING
//  1. No overlap: car (100,300), obs0 (300,100), all valid, tick -> busy high N_OBS cycles; reset_game never 1; lives=3.
//  2. Overlap: car (100,300), obs2 (120,320), tick at t -> reset_game=1 only at t+5 (N_OBS=4); hit_idx=2; lives=2; invuln=1.
//  3. Edge touch and wrap:
//     - car_h=100, obs_h=140 (CAR_W=40) -> no hit.
//     - obs_h=1000, car_h=1010 -> hit with no 10-bit wrap false negatives.
//  4. Multi-hit/valid: obs1 and obs3 overlap, obs_valid=4'b1101 -> hit_idx=3; obs_valid=4'b0000 -> no hit.
//  5. Hold and game over:
//     - Persistent overlap, HOLD_FRAMES=2 -> hits separated by exactly 3 ticks.
//     - Third hit -> lives=0, game_over=1; further ticks produce no pulse.
//  6. Restart/reset mid-scan:
//     - restart at t+2 of a hitting scan -> no reset_game; lives=3; IDLE.
//     - rst_n low mid-HOLD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/collision_scanner_if.sv
// Signal bundle between the object-position logic (master) and the
// collision scanner (slave). Status outputs flow back to the master side.
interface collision_scanner_if #(
  parameter int N_OBS = 4,
  parameter int H_W   = 10,
  parameter int V_W   = 9
);
  localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;

  logic                   frame_tick;
  logic                   restart;
  logic [H_W-1:0]         car_h_pos;
  logic [V_W-1:0]         car_v_pos;
  logic [N_OBS*H_W-1:0]   obs_h_flat;
  logic [N_OBS*V_W-1:0]   obs_v_flat;
  logic [N_OBS-1:0]       obs_valid;
  logic                   busy;
  logic                   reset_game;
  logic [IDX_W-1:0]       hit_idx;
  logic [3:0]             lives;
  logic                   invuln;
  logic                   game_over;

  modport master (
    output frame_tick, restart, car_h_pos, car_v_pos,
           obs_h_flat, obs_v_flat, obs_valid,
    input  busy, reset_game, hit_idx, lives, invuln, game_over
  );

  modport slave (
    input  frame_tick, restart, car_h_pos, car_v_pos,
           obs_h_flat, obs_v_flat, obs_valid,
    output busy, reset_game, hit_idx, lives, invuln, game_over
  );
endinterface

// File: rtl/collision_scanner.sv
// Sequential car/obstacle collision scanner. Snapshots positions on each
// frame_tick, tests one obstacle per clock with a full rectangle overlap,
// and manages lives, a frame-counted invulnerability window and game over.
module collision_scanner #(
  parameter int N_OBS       = 4,
  parameter int H_W         = 10,
  parameter int V_W         = 9,
  parameter int CAR_W       = 40,
  parameter int CAR_H       = 60,
  parameter int OBS_W       = 50,
  parameter int OBS_H       = 50,
  parameter int HOLD_FRAMES = 60,
  parameter int LIVES       = 3
) (
  input logic               clk,
  input logic               rst_n,
  collision_scanner_if.slave bus
);
  localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int HC_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [H_W:0]   CAR_W_X  = (H_W+1)'(CAR_W);
  localparam logic [H_W:0]   OBS_W_X  = (H_W+1)'(OBS_W);
  localparam logic [V_W:0]   CAR_H_X  = (V_W+1)'(CAR_H);
  localparam logic [V_W:0]   OBS_H_X  = (V_W+1)'(OBS_H);
  localparam logic [3:0]     LIVES_X  = 4'(LIVES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBS - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, HIT, HOLD, OVER} state_t;

  state_t state, state_n;

  // Snapshot of positions taken at scan start
  logic [H_W-1:0]   car_h_s;
  logic [V_W-1:0]   car_v_s;
  logic [H_W-1:0]   obs_h_s [N_OBS];
  logic [V_W-1:0]   obs_v_s [N_OBS];
  logic [N_OBS-1:0] valid_s;

  logic [IDX_W-1:0] idx;
  logic             found;
  logic [IDX_W-1:0] found_idx;
  logic [HC_W-1:0]  hold_cnt;

  logic             busy_q;
  logic             reset_game_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [3:0]       lives_q;
  logic             invuln_q;
  logic             game_over_q;

  logic             hit_now;
  logic             last_idx;
  logic             hold_last;
  logic             scan_hit;

  logic [H_W:0] car_l, car_r, ob_l, ob_r;
  logic [V_W:0] car_t, car_b, ob_t, ob_b;

  // Overlap test of the currently indexed obstacle, sums one bit wider so
  // right/bottom edges near the coordinate limit cannot wrap.
  always_comb begin
    car_l   = {1'b0, car_h_s};
    car_r   = car_l + CAR_W_X;
    ob_l    = {1'b0, obs_h_s[idx]};
    ob_r    = ob_l + OBS_W_X;
    car_t   = {1'b0, car_v_s};
    car_b   = car_t + CAR_H_X;
    ob_t    = {1'b0, obs_v_s[idx]};
    ob_b    = ob_t + OBS_H_X;
    hit_now = valid_s[idx] &&
              (car_l < ob_r) && (ob_l < car_r) &&
              (car_t < ob_b) && (ob_t < car_b);
  end

  assign last_idx  = (idx == LAST_IDX);
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign scan_hit  = found || hit_now;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; restart overrides every state
  always_comb begin
    state_n = state;
    if (bus.restart) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.frame_tick) state_n = SCAN;
        SCAN: if (last_idx) state_n = scan_hit ? HIT : IDLE;
        // game_over was already registered on entry to HIT
        HIT:  state_n = game_over_q ? OVER : HOLD;
        HOLD: if (bus.frame_tick && hold_last) state_n = IDLE;
        OVER: state_n = OVER;
        default: state_n = IDLE;
      endcase
    end
  end

  // Snapshot capture, scan index, first-hit latch and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_h_s   <= '0;
      car_v_s   <= '0;
      valid_s   <= '0;
      for (int unsigned i = 0; i < N_OBS; i++) begin
        obs_h_s[i] <= '0;
        obs_v_s[i] <= '0;
      end
      idx       <= '0;
      found     <= 1'b0;
      found_idx <= '0;
      hold_cnt  <= '0;
    end else if (bus.restart) begin
      idx       <= '0;
      found     <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.frame_tick) begin
            car_h_s <= bus.car_h_pos;
            car_v_s <= bus.car_v_pos;
            valid_s <= bus.obs_valid;
            for (int unsigned i = 0; i < N_OBS; i++) begin
              obs_h_s[i] <= bus.obs_h_flat[i*H_W +: H_W];
              obs_v_s[i] <= bus.obs_v_flat[i*V_W +: V_W];
            end
            idx   <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          idx <= idx + IDX_W'(1);
          if (hit_now && !found) begin
            found     <= 1'b1;
            found_idx <= idx;
          end
        end
        HIT:  hold_cnt <= '0;
        HOLD: if (bus.frame_tick) hold_cnt <= hold_last ? '0 : hold_cnt + HC_W'(1);
        default: ;
      endcase
    end
  end

  // Registered outputs; the hit bookkeeping is done on the edge entering HIT
  // so the pulse, index and lives all appear in the HIT cycle together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      reset_game_q <= 1'b0;
      hit_idx_q    <= '0;
      lives_q      <= LIVES_X;
      invuln_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      busy_q       <= (state_n == SCAN);
      invuln_q     <= (state_n == HOLD);
      reset_game_q <= (state_n == HIT) && (state == SCAN);
      if (bus.restart) begin
        lives_q     <= LIVES_X;
        game_over_q <= 1'b0;
      end else if (state == SCAN && last_idx && scan_hit) begin
        hit_idx_q   <= found ? found_idx : idx;
        lives_q     <= (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
        game_over_q <= (lives_q <= 4'd1);
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.reset_game = reset_game_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.lives      = lives_q;
  assign bus.invuln     = invuln_q;
  assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner (N_OBS=4, HOLD_FRAMES=2).
module tb_collision_scanner;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  collision_scanner_if #(.N_OBS(4), .H_W(10), .V_W(9)) bus ();

  collision_scanner #(
    .N_OBS(4), .H_W(10), .V_W(9), .CAR_W(40), .CAR_H(60),
    .OBS_W(50), .OBS_H(50), .HOLD_FRAMES(2), .LIVES(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obs(input int i, input int h, input int v);
    bus.obs_h_flat[i*10 +: 10] = 10'(h);
    bus.obs_v_flat[i*9 +: 9]   = 9'(v);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) set_obs(i, 300, 100);
    bus.car_h_pos = 10'd100;
    bus.car_v_pos = 9'd300;
    bus.obs_valid = 4'b1111;
  endtask

  // Pulse frame_tick, then observe 10 cycles; sample 0 is the cycle after the tick edge
  task automatic scan(output int rg_cnt, output int rg_first, output int busy_cnt);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    rg_cnt = 0; rg_first = -1; busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.reset_game === 1'b1) begin
        if (rg_first < 0) rg_first = k;
        rg_cnt++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      step();
    end
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    tests++; if (bus.reset_game !== 1'b0) begin fails++; $display("FAIL reset_rg got %b exp 0", bus.reset_game); end
    tests++; if (bus.hit_idx !== 2'd0) begin fails++; $display("FAIL reset_hit_idx got %0d exp 0", bus.hit_idx); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL reset_lives got %0d exp 3", bus.lives); end
    tests++; if (bus.invuln !== 1'b0) begin fails++; $display("FAIL reset_invuln got %b exp 0", bus.invuln); end
    tests++; if (bus.game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over got %b exp 0", bus.game_over); end
  endtask

  task automatic test_no_overlap();
    int c, f, b;
    clear_obs();
    scan(c, f, b);
    tests++; if (b !== 4) begin fails++; $display("FAIL noov_busy_cycles got %0d exp 4", b); end
    tests++; if (c !== 0) begin fails++; $display("FAIL noov_rg_count got %0d exp 0", c); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL noov_lives got %0d exp 3", bus.lives); end
  endtask

  task automatic test_overlap();
    int c, f, b;
    clear_obs();
    set_obs(2, 120, 320);
    scan(c, f, b);
    tests++; if (f !== 4) begin fails++; $display("FAIL ov_rg_cycle got %0d exp 4", f); end
    tests++; if (c !== 1) begin fails++; $display("FAIL ov_rg_count got %0d exp 1", c); end
    tests++; if (bus.hit_idx !== 2'd2) begin fails++; $display("FAIL ov_hit_idx got %0d exp 2", bus.hit_idx); end
    tests++; if (bus.lives !== 4'd2) begin fails++; $display("FAIL ov_lives got %0d exp 2", bus.lives); end
    tests++; if (bus.invuln !== 1'b1) begin fails++; $display("FAIL ov_invuln got %b exp 1", bus.invuln); end
    do_restart();
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL restart_lives got %0d exp 3", bus.lives); end
    tests++; if (bus.invuln !== 1'b0) begin fails++; $display("FAIL restart_invuln got %b exp 0", bus.invuln); end
  endtask

  task automatic test_edge_wrap();
    int c, f, b;
    clear_obs();
    set_obs(0, 140, 300);
    scan(c, f, b);
    tests++; if (c !== 0) begin fails++; $display("FAIL touch_h_rg got %0d exp 0", c); end
    set_obs(0, 100, 360);
    scan(c, f, b);
    tests++; if (c !== 0) begin fails++; $display("FAIL touch_v_rg got %0d exp 0", c); end
    set_obs(0, 139, 300);
    scan(c, f, b);
    tests++; if (c !== 1) begin fails++; $display("FAIL inside_1px_rg got %0d exp 1", c); end
    do_restart();
    clear_obs();
    bus.car_h_pos = 10'd1010;
    set_obs(0, 1000, 300);
    scan(c, f, b);
    tests++; if (c !== 1) begin fails++; $display("FAIL wrap_rg got %0d exp 1", c); end
    tests++; if (bus.hit_idx !== 2'd0) begin fails++; $display("FAIL wrap_hit_idx got %0d exp 0", bus.hit_idx); end
    do_restart();
  endtask

  task automatic test_multi_valid();
    int c, f, b;
    clear_obs();
    set_obs(1, 110, 310);
    set_obs(3, 90, 290);
    bus.obs_valid = 4'b1101;
    scan(c, f, b);
    tests++; if (bus.hit_idx !== 2'd3) begin fails++; $display("FAIL masked_hit_idx got %0d exp 3", bus.hit_idx); end
    tests++; if (c !== 1) begin fails++; $display("FAIL masked_rg got %0d exp 1", c); end
    do_restart();
    bus.obs_valid = 4'b1111;
    scan(c, f, b);
    tests++; if (bus.hit_idx !== 2'd1) begin fails++; $display("FAIL lowest_hit_idx got %0d exp 1", bus.hit_idx); end
    do_restart();
    bus.obs_valid = 4'b0000;
    scan(c, f, b);
    tests++; if (c !== 0) begin fails++; $display("FAIL none_valid_rg got %0d exp 0", c); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL none_valid_lives got %0d exp 3", bus.lives); end
  endtask

  task automatic test_hold_gameover();
    int c, f, b;
    int n_hits, total;
    int hit_at [3];
    clear_obs();
    set_obs(0, 110, 310);
    n_hits = 0; total = 0;
    for (int t = 0; t < 12; t++) begin
      scan(c, f, b);
      total += c;
      if (c > 0 && n_hits < 3) begin
        hit_at[n_hits] = t;
        n_hits++;
      end
    end
    tests++; if (total !== 3) begin fails++; $display("FAIL hold_total_rg got %0d exp 3", total); end
    tests++; if (n_hits == 3 && hit_at[1] - hit_at[0] !== 3) begin fails++; $display("FAIL hold_gap1 got %0d exp 3", hit_at[1] - hit_at[0]); end
    tests++; if (n_hits == 3 && hit_at[2] - hit_at[1] !== 3) begin fails++; $display("FAIL hold_gap2 got %0d exp 3", hit_at[2] - hit_at[1]); end
    tests++; if (bus.lives !== 4'd0) begin fails++; $display("FAIL over_lives got %0d exp 0", bus.lives); end
    tests++; if (bus.game_over !== 1'b1) begin fails++; $display("FAIL over_flag got %b exp 1", bus.game_over); end
    scan(c, f, b);
    tests++; if (b !== 0) begin fails++; $display("FAIL over_busy got %0d exp 0", b); end
    do_restart();
    tests++; if (bus.game_over !== 1'b0) begin fails++; $display("FAIL over_restart_flag got %b exp 0", bus.game_over); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL over_restart_lives got %0d exp 3", bus.lives); end
  endtask

  task automatic test_restart_scan();
    int c, f, b;
    clear_obs();
    set_obs(2, 120, 320);
    // restart sampled at the second scan edge
    bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
    step();
    bus.restart = 1'b1; step(); bus.restart = 1'b0;
    c = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.reset_game === 1'b1) c++;
      step();
    end
    tests++; if (c !== 0) begin fails++; $display("FAIL abort_rg got %0d exp 0", c); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL abort_lives got %0d exp 3", bus.lives); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    // restart sampled on the edge that would enter HIT
    bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
    step(); step(); step();
    bus.restart = 1'b1; step(); bus.restart = 1'b0;
    c = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.reset_game === 1'b1) c++;
      step();
    end
    tests++; if (c !== 0) begin fails++; $display("FAIL suppress_hit_rg got %0d exp 0", c); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL suppress_hit_lives got %0d exp 3", bus.lives); end
    // simultaneous tick and restart: no scan
    bus.frame_tick = 1'b1; bus.restart = 1'b1; step();
    bus.frame_tick = 1'b0; bus.restart = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL tick_restart_busy got %b exp 0", bus.busy); end
    step(); step();
  endtask

  task automatic test_snapshot();
    int c;
    clear_obs();
    bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
    set_obs(0, 110, 310);
    c = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.reset_game === 1'b1) c++;
      step();
    end
    tests++; if (c !== 0) begin fails++; $display("FAIL snapshot_rg got %0d exp 0", c); end
    clear_obs();
  endtask

  task automatic test_reset_mid_hold();
    int c, f, b;
    clear_obs();
    set_obs(1, 110, 310);
    scan(c, f, b);
    tests++; if (bus.invuln !== 1'b1) begin fails++; $display("FAIL pre_rst_invuln got %b exp 1", bus.invuln); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.invuln !== 1'b0) begin fails++; $display("FAIL rst_hold_invuln got %b exp 0", bus.invuln); end
    tests++; if (bus.lives !== 4'd3) begin fails++; $display("FAIL rst_hold_lives got %0d exp 3", bus.lives); end
    tests++; if (bus.hit_idx !== 2'd0) begin fails++; $display("FAIL rst_hold_hit_idx got %0d exp 0", bus.hit_idx); end
    tests++; if (bus.game_over !== 1'b0 || bus.busy !== 1'b0 || bus.reset_game !== 1'b0) begin
      fails++; $display("FAIL rst_hold_flags got go=%b busy=%b rg=%b exp 0 0 0", bus.game_over, bus.busy, bus.reset_game);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.restart    = 1'b0;
    bus.obs_h_flat = '0;
    bus.obs_v_flat = '0;
    clear_obs();
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_no_overlap();
    test_overlap();
    test_edge_wrap();
    test_multi_valid();
    test_hold_gameover();
    test_restart_scan();
    test_snapshot();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
